// File: rtl/oled_pkg.sv
// Shared constants, SSD1331-style command table and FSM states for the OLED scanner.
// Defining OLED_TESTPAT_EN adds the x/y test-pattern pixel generator.
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int OLED_NPIX = 6144;
  localparam int OLED_NCMD = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PIXELS,
    ST_GAP
  } oled_state_e;

  // Column window 0..95, then row window 0..63
  function automatic logic [7:0] oled_cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h15;
      3'd1:    return 8'h00;
      3'd2:    return 8'h5F;
      3'd3:    return 8'h75;
      3'd4:    return 8'h00;
      3'd5:    return 8'h3F;
      default: return 8'h00;
    endcase
  endfunction

`ifdef OLED_TESTPAT_EN
  function automatic logic [15:0] oled_testpat_word(input logic [12:0] idx);
    logic [4:0] xh;
    logic [5:0] y;
    xh = 5'((idx % 13'(OLED_W)) >> 2);
    y  = 6'(idx / 13'(OLED_W));
    return {xh, y, xh};
  endfunction
`endif

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 MSB-first shifter: 8- or 16-bit loads, SCLK_DIV cycles per sclk half-period.
// done marks the last cycle of a word, so a reload that same cycle streams words back to back.
module spi_shifter #(
  parameter int SCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        wide,
  input  logic [15:0] din,
  output logic        sclk,
  output logic        sdata,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic        half_q, half_d;
  logic        busy_q, busy_d;
  logic        div_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      half_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      half_q    <= half_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    half_d    = half_q;
    busy_d    = busy_q;
    div_end   = (div_cnt_q == DIV_LAST);
    done      = busy_q && half_q && div_end && (bit_cnt_q == 4'd0);
    if (load) begin
      // Byte loads are left-aligned so bit 15 is always the next bit out
      shift_d   = wide ? din : {din[7:0], 8'h00};
      bit_cnt_d = wide ? 4'd15 : 4'd7;
      div_cnt_d = 4'd0;
      half_d    = 1'b0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      div_cnt_d = div_end ? 4'd0 : div_cnt_q + 4'd1;
      if (div_end) begin
        half_d = ~half_q;
        if (half_q) begin
          if (bit_cnt_q == 4'd0) begin
            busy_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            shift_d   = {shift_q[14:0], 1'b0};
          end
        end
      end
    end
  end

  assign sclk  = busy_q & half_q;
  assign sdata = busy_q & shift_q[15];
  assign busy  = busy_q;

endmodule

// File: rtl/oled_spi_scanner.sv
// Streams a command header then a full RGB565 frame to a 96x64 OLED over SPI, with an idle gap.
// NUM_PIXELS shortens the frame for simulation; macro OLED_TESTPAT_EN replaces pixel_data by an x/y pattern.
module oled_spi_scanner
  import oled_pkg::*;
#(
  parameter int SCLK_DIV   = 2,
  parameter int FRAME_GAP  = 1000,
  parameter int NUM_PIXELS = OLED_NPIX
) (
  input  logic        my_clk_25m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdata,
  output logic        dc
);

  localparam logic [12:0] LAST_PIX = 13'(NUM_PIXELS - 1);
  localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);

  oled_state_e state_q, state_d;
  logic [2:0]  cmd_idx_q, cmd_idx_d;
  logic [12:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [12:0] next_pix;
  logic [15:0] pixel_word;
  logic        sh_load, sh_wide, sh_busy, sh_done, sh_sclk, sh_sdata;
  logic [15:0] sh_din;

`ifdef OLED_TESTPAT_EN
  logic unused_pixel_data;
  assign unused_pixel_data = ^pixel_data;
  assign pixel_word        = oled_testpat_word(pix_cnt_q);
`else
  assign pixel_word = pixel_data;
`endif

  spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk   (my_clk_25m),
    .rst_n (rst_n),
    .load  (sh_load),
    .wide  (sh_wide),
    .din   (sh_din),
    .sclk  (sh_sclk),
    .sdata (sh_sdata),
    .busy  (sh_busy),
    .done  (sh_done)
  );

  always_ff @(posedge my_clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_idx_q <= '0;
      pix_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      pix_cnt_q <= pix_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Pixel sampling happens on the done cycle; the counter moves one cycle later
  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    pix_cnt_d = pix_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sh_load   = 1'b0;
    sh_wide   = 1'b0;
    sh_din    = {8'h00, oled_cmd_byte(cmd_idx_q)};
    next_pix  = (pix_cnt_q == LAST_PIX) ? 13'd0 : pix_cnt_q + 13'd1;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (!sh_busy || (sh_done && cmd_idx_q != 3'(OLED_NCMD))) begin
          sh_load   = 1'b1;
          cmd_idx_d = cmd_idx_q + 3'd1;
        end else if (sh_done) begin
          sh_load   = 1'b1;
          sh_wide   = 1'b1;
          sh_din    = pixel_word;
          pix_cnt_d = next_pix;
          cmd_idx_d = 3'd0;
          state_d   = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        // pix_cnt_q only reads 0 here once the final pixel has been sampled
        if (sh_done) begin
          if (pix_cnt_q == 13'd0) begin
            state_d = ST_GAP;
          end else begin
            sh_load   = 1'b1;
            sh_wide   = 1'b1;
            sh_din    = pixel_word;
            pix_cnt_d = next_pix;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 16'd0;
          state_d   = enable ? ST_CMD : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_begin    = (state_q == ST_CMD) && !sh_busy;
    sending_pixels = (state_q == ST_PIXELS);
    dc             = (state_q == ST_PIXELS);
    cs_n           = !sh_busy;
    sclk           = sh_sclk;
    sdata          = sh_sdata;
    pixel_index    = pix_cnt_q;
  end

endmodule

// File: tb/tb_oled_spi_scanner.sv
// Self-checking bench for oled_spi_scanner: a timing-formula reference model checked every cycle,
// an SPI decoder, and literal checks of command bytes, pixel words and frame spacing.
module tb_oled_spi_scanner;

  localparam int D      = 2;
  localparam int FG     = 1000;
  localparam int NP     = 100;
  localparam int BITS   = 48 + 16 * NP;
  localparam int LEN    = BITS * 2 * D;
  localparam int LAST   = LEN + FG;
  localparam int PERIOD = (6 * 8 + NP * 16) * 2 * D + FG + 1;

  logic        my_clk_25m = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b0;
  logic [15:0] pixel_data = 16'h0000;
  logic [12:0] pixel_index;
  logic        frame_begin, sending_pixels, cs_n, sclk, sdata, dc;

  int total = 0;
  int bad   = 0;

  oled_spi_scanner #(.SCLK_DIV(D), .FRAME_GAP(FG), .NUM_PIXELS(NP)) dut (
    .my_clk_25m     (my_clk_25m),
    .rst_n          (rst_n),
    .enable         (enable),
    .pixel_data     (pixel_data),
    .pixel_index    (pixel_index),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .cs_n           (cs_n),
    .sclk           (sclk),
    .sdata          (sdata),
    .dc             (dc)
  );

  always #20 my_clk_25m = ~my_clk_25m;

  // Renderer with one cycle of registered latency
  always @(posedge my_clk_25m) begin
`ifdef OLED_TESTPAT_EN
    pixel_data <= 16'($urandom);
`else
    pixel_data <= {3'b000, pixel_index};
`endif
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e);
    @(posedge my_clk_25m);
    #1;
    rst_n  = r;
    enable = e;
  endtask

  logic [7:0] cmd_ref [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};

  function automatic logic [15:0] exp_word(input int p);
`ifdef OLED_TESTPAT_EN
    logic [6:0] xv;
    logic [5:0] yv;
    xv = 7'(p % 96);
    yv = 6'(p / 96);
    return {xv[6:2], yv, xv[6:2]};
`else
    return 16'(p);
`endif
  endfunction

  function automatic logic exp_bit(input int b);
    logic [7:0]  cb;
    logic [15:0] w;
    if (b < 48) begin
      cb = cmd_ref[b / 8];
      return cb[7 - (b % 8)];
    end
    w = exp_word((b - 48) / 16);
    return w[15 - ((b - 48) % 16)];
  endfunction

  // Frame model: m_t counts cycles since frame_begin; frame_begin recurs only if enable is seen at the last gap cycle
  bit m_active = 1'b0;
  int m_t      = 0;
  always @(posedge my_clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      if (enable) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (m_t == LAST) begin
      if (enable) m_t = 0;
      else m_active = 1'b0;
    end else begin
      m_t++;
    end
  end

  int cyc      = 0;
  int fb_count = 0;
  int last_fb  = 0;
  int spacing_q [$];

  always @(negedge my_clk_25m) begin
    logic e_fb, e_cs, e_sclk, e_sd, e_dc;
    int   e_idx, b, ph, c;
    cyc++;
    e_fb = 0; e_cs = 1; e_sclk = 0; e_sd = 0; e_dc = 0; e_idx = 0;
    if (m_active && m_t == 0) e_fb = 1;
    if (m_active && m_t >= 1 && m_t <= LEN) begin
      b      = (m_t - 1) / (2 * D);
      ph     = (m_t - 1) % (2 * D);
      e_cs   = 0;
      e_sclk = (ph >= D);
      e_sd   = exp_bit(b);
      e_dc   = (b >= 48);
      if (m_t > 96 * D) begin
        c     = (m_t - 1 - 96 * D) / (32 * D) + 1;
        e_idx = (c >= NP) ? 0 : c;
      end
    end
    checkOutput("frame_begin", frame_begin, e_fb);
    checkOutput("cs_n", cs_n, e_cs);
    checkOutput("sclk", sclk, e_sclk);
    checkOutput("sdata", sdata, e_sd);
    checkOutput("dc", dc, e_dc);
    checkOutput("sending_pixels", sending_pixels, e_dc);
    checkOutput("pixel_index", pixel_index, e_idx);
    if (frame_begin) begin
      fb_count++;
      if (fb_count > 1) spacing_q.push_back(cyc - last_fb);
      last_fb = cyc;
    end
  end

  // SPI mode-0 decoder: sample on sclk rise while selected
  logic [15:0] mon_acc = 16'h0000;
  int          mon_n   = 0;
  logic [7:0]  bytes_q [$];
  logic [15:0] words_q [$];
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      mon_acc = 16'h0000;
      mon_n   = 0;
    end else if (!cs_n) begin
      mon_acc = {mon_acc[14:0], sdata};
      mon_n++;
      if (!dc && mon_n == 8) begin
        bytes_q.push_back(mon_acc[7:0]);
        mon_n = 0;
      end else if (dc && mon_n == 16) begin
        words_q.push_back(mon_acc);
        mon_n = 0;
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cs_n"}, cs_n, 1'b1);
    checkOutput({tag, "_sclk"}, sclk, 1'b0);
    checkOutput({tag, "_sdata"}, sdata, 1'b0);
    checkOutput({tag, "_dc"}, dc, 1'b0);
    checkOutput({tag, "_frame_begin"}, frame_begin, 1'b0);
    checkOutput({tag, "_sending"}, sending_pixels, 1'b0);
    checkOutput({tag, "_pixel_index"}, pixel_index, 13'd0);
  endtask

  initial begin
    logic [7:0] lit_cmd [6];
    logic [7:0] pin_byte;
    int         drop_px;
    lit_cmd = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};

    repeat (3) @(negedge my_clk_25m);
    checkResetValues("reset");

    for (int i = 0; i < 8; i++) pin_byte[7 - i] = exp_bit(16 + i);
    checkOutput("pin_model_cmd2", pin_byte, 8'h5F);
`ifdef OLED_TESTPAT_EN
    checkOutput("pin_model_last_pixel", exp_word(6143), 16'hBFF7);
`else
    checkOutput("pin_model_last_pixel", exp_word(6143), 16'h17FF);
`endif

    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3 * PERIOD + 500 && fb_count < 3; i++) @(negedge my_clk_25m);
    checkOutput("frames_started", fb_count, 3);
    checkOutput("cmd_bytes_seen", bytes_q.size() >= 6, 1'b1);
    if (bytes_q.size() >= 6)
      for (int i = 0; i < 6; i++) checkOutput($sformatf("cmd_byte%0d", i), bytes_q[i], lit_cmd[i]);
    checkOutput("spacing_count", spacing_q.size(), 2);
    foreach (spacing_q[i]) checkOutput("frame_spacing", spacing_q[i], PERIOD);
    checkOutput("two_frame_words", words_q.size(), 2 * NP);
    foreach (words_q[i]) checkOutput($sformatf("pix_word%0d", i), words_q[i], exp_word(i % NP));
    words_q.delete();

    drop_px = $urandom_range(10, NP - 10);
    for (int i = 0; i < PERIOD && pixel_index != 13'(drop_px); i++) @(negedge my_clk_25m);
    checkOutput("reach_drop_pixel", pixel_index, drop_px);
    applyStimulus(1'b1, 1'b0);
    repeat (PERIOD + 200) @(negedge my_clk_25m);
    checkOutput("no_frame_after_drop", fb_count, 3);
    checkOutput("dropped_frame_words", words_q.size(), NP);
    if (words_q.size() > 0) checkOutput("dropped_frame_last", words_q[$], exp_word(NP - 1));
    checkOutput("idle_cs_n", cs_n, 1'b1);

    bytes_q.delete();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 20 && !frame_begin; i++) @(negedge my_clk_25m);
    checkOutput("restart_frame_begin", frame_begin, 1'b1);
    repeat (1 + (3 * 8 + 4) * 2 * D) @(posedge my_clk_25m);
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("midbyte_reset");
    checkOutput("bytes_before_reset", bytes_q.size(), 3);
    repeat (2) @(negedge my_clk_25m);
    bytes_q.delete();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 200 && bytes_q.size() == 0; i++) @(negedge my_clk_25m);
    checkOutput("restart_byte_seen", bytes_q.size() > 0, 1'b1);
    if (bytes_q.size() > 0) checkOutput("restart_byte0", bytes_q[0], 8'h15);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(50, 1500)) @(negedge my_clk_25m);
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b0, enable);
        applyStimulus(1'b1, enable);
      end
    end
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge my_clk_25m);
    checkResetValues("final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
